button_debounce: RTL and testbench



---
 rtl/button_debounce.sv | 152 +++++++++++++++
 tb/tb_button_debounce.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// button_debounce: multi-channel push-button debouncer feeding one_pulse.
// Raw pins are polarity-corrected, optionally synchronized, and each level
// change is accepted only after it holds for STABLE_TICKS prescaler ticks.
// Optional feature macro: BUTTON_DEBOUNCE_SYNC_EN
//   defined   -> 2-flop synchronizer per channel (s lags pin by 2 cycles)
//   undefined -> s is the polarity-corrected pin directly (pre-synchronized input)

module button_debounce #(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned STABLE_TICKS = 10,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] pb_in,
  output logic [N_BTN-1:0] pb_debounced,
  output logic             tick
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [N_BTN-1:0] POL_MASK = {N_BTN{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    REL   = 2'd0,
    W_PRS = 2'd1,
    PRS   = 2'd2,
    W_REL = 2'd3
  } state_t;

  logic [N_BTN-1:0] pb_pol;
  logic [N_BTN-1:0] s;
  logic [DIV_W-1:0] div_cnt;

  // Polarity correction: after this point 1 always means pressed.
  assign pb_pol = pb_in ^ POL_MASK;

`ifdef BUTTON_DEBOUNCE_SYNC_EN
  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;

  // Two-flop synchronizer; resets to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= pb_pol;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = pb_pol;
`endif

  // Shared prescaler: one-cycle tick on the cycle after the counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= (div_cnt == DIV_LAST);
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  genvar i;
  for (i = 0; i < int'(N_BTN); i++) begin : g_ch
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_d;
    logic             out_q;

    // Next-state: a reverting input always wins over tick counting.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = 1'b0;
      case (state_q)
        REL: begin
          if (s[i]) begin
            state_d = W_PRS;
            cnt_d   = '0;
          end
        end
        W_PRS: begin
          if (!s[i]) begin
            state_d = REL;
          end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
              state_d = PRS;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        PRS: begin
          if (!s[i]) begin
            state_d = W_REL;
            cnt_d   = '0;
          end
        end
        W_REL: begin
          if (s[i]) begin
            state_d = PRS;
          end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
              state_d = REL;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = REL;
          cnt_d   = '0;
        end
      endcase
      out_d = (state_d == PRS) || (state_d == W_REL);
    end

    // State, stability counter and registered debounced level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= REL;
        cnt_q   <= '0;
        out_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
      end
    end

    assign pb_debounced[i] = out_q;
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios followed by random pin
// activity, checked every cycle against a run-length / tick-count model.

module tb_button_debounce;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int ST = 3;
`ifdef BUTTON_DEBOUNCE_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif
  localparam int LAT_LO = (ST - 1) * TD + 2 + SYNC_D;
  localparam int LAT_HI = ST * TD + 1 + SYNC_D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] pb_in = '0;
  logic [N-1:0] pb_debounced;
  logic         tick;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: accepted level per channel, plus the tick count at the
  // moment the pin started to disagree with it.
  int           edge_n;
  int           tick_cum;
  bit           tick_vis;
  bit [N-1:0]   m_out;
  bit [N-1:0]   run_on;
  int           run_cum [N];
  logic [N-1:0] pipe [$];
  bit           ch1_ever;

  always #5 clk = ~clk;

  button_debounce #(
    .N_BTN       (N),
    .TICK_DIV    (TD),
    .STABLE_TICKS(ST),
    .ACTIVE_LOW  (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pb_in       (pb_in),
    .pb_debounced(pb_debounced),
    .tick        (tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_range(input string tag, input int got, input int lo, input int hi);
    n_checks++;
    assert (got >= lo && got <= hi) n_pass++;
    else $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
  endtask

  task automatic model_reset();
    edge_n   = 0;
    tick_cum = 0;
    tick_vis = 1'b0;
    m_out    = '0;
    run_on   = '0;
    pipe.delete();
    repeat (SYNC_D) pipe.push_back('0);
  endtask

  // One clock edge of the reference behaviour, given the pin value sampled there.
  task automatic model_edge(input logic [N-1:0] v);
    logic [N-1:0] s;
    edge_n++;
    if (tick_vis) tick_cum++;
    pipe.push_back(v);
    s = pipe.pop_front();
    for (int c = 0; c < N; c++) begin
      if (s[c] == m_out[c]) begin
        run_on[c] = 1'b0;
      end else if (!run_on[c]) begin
        run_on[c]  = 1'b1;
        run_cum[c] = tick_cum;
      end else if (tick_cum - run_cum[c] >= ST) begin
        m_out[c]  = s[c];
        run_on[c] = 1'b0;
      end
    end
    tick_vis = (edge_n % TD == 0);
  endtask

  // Drive pins at the falling edge, let one rising edge pass, check outputs.
  task automatic cycle(input logic [N-1:0] v);
    pb_in = v;
    @(posedge clk);
    if (rst_n) model_edge(v);
    @(negedge clk);
    if (rst_n) begin
      check("pb_debounced", 32'(pb_debounced), 32'(m_out));
      check("tick", 32'(tick), 32'(tick_vis));
    end else begin
      check("rst_pb_debounced", 32'(pb_debounced), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
    end
    if (pb_debounced[1]) ch1_ever = 1'b1;
  endtask

  task automatic do_reset(input int n, input logic [N-1:0] v);
    rst_n = 1'b0;
    model_reset();
    repeat (n) cycle(v);
    rst_n = 1'b1;
  endtask

  // Hold pins at v until channel ch reaches tgt; n = cycles taken or -1.
  task automatic run_until(input logic [N-1:0] v, input int ch, input logic tgt, output int n);
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      cycle(v);
      if (pb_debounced[ch] === tgt) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    int           n;
    int           first;
    logic [N-1:0] v;
    logic [N-1:0] bounce;

    ch1_ever = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset held with all pins pressed.
    do_reset(5, 4'b1111);

    // First tick after release.
    first = -1;
    for (int c = 1; c <= TD + 2; c++) begin
      cycle('0);
      if (tick && first < 0) first = c;
    end
    check("first_tick", 32'(first), 32'(TD));
    repeat (10) cycle('0);

    // Clean press on channel 0.
    run_until(4'b0001, 0, 1'b1, n);
    check_range("press_lat_ch0", n, LAT_LO, LAT_HI);
    check("press_others_low", 32'(pb_debounced[3:1]), 32'd0);
    repeat (5) cycle(4'b0001);
    repeat (20) cycle('0);

    // Bounce on channel 1: 3-cycle pulses never qualify.
    ch1_ever = 1'b0;
    for (int c = 0; c < 40; c++) cycle(((c / 3) % 2 == 0) ? 4'b0010 : 4'b0000);
    repeat (20) cycle('0);
    check("bounce_ch1_never_high", 32'(ch1_ever), 32'd0);

    // Release with bounce on channel 2.
    repeat (20) cycle(4'b0100);
    check("ch2_pressed", 32'(pb_debounced[2]), 32'd1);
    repeat (5) cycle(4'b0000);
    check("ch2_held_low5", 32'(pb_debounced[2]), 32'd1);
    cycle(4'b0100);
    check("ch2_held_glitch", 32'(pb_debounced[2]), 32'd1);
    run_until(4'b0000, 2, 1'b0, n);
    check_range("release_lat_ch2", n, LAT_LO, LAT_HI);
    repeat (10) cycle('0);

    // Simultaneous press on all channels.
    first = -1;
    for (int c = 1; c <= 40; c++) begin
      cycle(4'b1111);
      if (pb_debounced != '0) begin
        first = c;
        break;
      end
    end
    check("simul_all_rise", 32'(pb_debounced), 32'hF);
    check_range("simul_lat", first, LAT_LO, LAT_HI);
    repeat (20) cycle('0);

    // Reset in the middle of a qualification.
    repeat (6) cycle(4'b1000);
    do_reset(3, 4'b1000);
    run_until(4'b1000, 3, 1'b1, n);
    check_range("rst_mid_lat", n, LAT_LO, LAT_HI);
    repeat (20) cycle('0);

    // Random segments: some channels bounce, others settle at a random level.
    v = '0;
    for (int seg = 0; seg < 60; seg++) begin
      bounce = N'($urandom);
      for (int c = 0; c < N; c++)
        if (!bounce[c]) v[c] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) do_reset(int'($urandom_range(1, 4)), v);
      for (int k = int'($urandom_range(5, 40)); k > 0; k--) begin
        for (int c = 0; c < N; c++)
          if (bounce[c] && $urandom_range(0, 2) == 0) v[c] = ~v[c];
        cycle(v);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
